// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and baud divider helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_e;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 11;

   // Integer-truncated clocks per bit, or per half bit when half is set.
   function automatic int unsigned uart_baud_cnt(input int unsigned freq,
                                                 input int unsigned baud,
                                                 input logic        half);
      int unsigned full;
      full = freq / baud;
      return half ? (full / 2) : full;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge (start) detector.
module uart_rx_sync (
   input  logic clk_rx,
   input  logic rst_n,
   input  logic rx_in,
   output logic rx_s,
   output logic start_edge
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Line idles high, so every stage resets to 1 to avoid a false start edge.
   always_ff @(posedge clk_rx or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= rx_in;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign rx_s       = r_sync;
   assign start_edge = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8E1 UART receiver with mid-bit sampling; UART_RX_MAJORITY_EN selects 2-of-3 sampling per bit.
//
// state  | meaning
// IDLE   | line idle, waiting for start edge while en is high
// START  | confirming start bit at half-bit point
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing even-parity bit
// STOP   | sampling stop bit, publishing byte and flags
// BREAK  | stop bit was low, waiting for line to return high
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned frequency = 100_000_000,
   parameter int unsigned BAUD      = 9600
) (
   input  logic       clk_rx,
   input  logic       rst_n,
   input  logic       en,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned BIT_CNT  = uart_baud_cnt(frequency, BAUD, 1'b0);
   localparam int unsigned HALF_CNT = uart_baud_cnt(frequency, BAUD, 1'b1);

`ifdef UART_RX_MAJORITY_EN
   localparam logic [13:0] BIT_TGT  = 14'(BIT_CNT);
   localparam logic [13:0] HALF_TGT = 14'(HALF_CNT);
`else
   localparam logic [13:0] BIT_TGT  = 14'(BIT_CNT - 1);
   localparam logic [13:0] HALF_TGT = 14'(HALF_CNT - 1);
`endif

   logic                 w_rx_s;
   logic                 w_start_edge;
   logic                 w_sample;
   logic                 w_half_hit;
   logic                 w_bit_hit;

   uart_state_e          r_state;
   logic [13:0]          r_baud_cnt;
   logic [2:0]           r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bit;
   logic [7:0]           r_data;
   logic                 r_valid;
   logic                 r_par_err;
   logic                 r_frm_err;

   uart_rx_sync u_sync (
      .clk_rx     (clk_rx),
      .rst_n      (rst_n),
      .rx_in      (rx_in),
      .rx_s       (w_rx_s),
      .start_edge (w_start_edge)
   );

`ifdef UART_RX_MAJORITY_EN
   // History of the two previous rx_s values; with the live value they span target-1..target+1.
   logic [1:0] r_hist;

   always_ff @(posedge clk_rx or negedge rst_n) begin
      if (!rst_n) r_hist <= 2'b11;
      else        r_hist <= {r_hist[0], w_rx_s};
   end

   assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
   assign w_sample = w_rx_s;
`endif

   assign w_half_hit = (r_baud_cnt == HALF_TGT);
   assign w_bit_hit  = (r_baud_cnt == BIT_TGT);

   always_ff @(posedge clk_rx or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_par_bit  <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_par_err  <= 1'b0;
         r_frm_err  <= 1'b0;
      end else begin
         r_valid    <= 1'b0;
         r_baud_cnt <= (r_state == IDLE) ? '0 : r_baud_cnt + 14'd1;
         case (r_state)
            IDLE: begin
               if (en && w_start_edge) begin
                  r_state    <= START;
                  r_baud_cnt <= '0;
               end
            end
            START: begin
               if (w_half_hit) begin
                  r_baud_cnt <= '0;
                  r_bit_idx  <= '0;
                  r_state    <= w_sample ? IDLE : DATA;
               end
            end
            DATA: begin
               if (w_bit_hit) begin
                  r_baud_cnt <= '0;
                  r_shift    <= {w_sample, r_shift[DATA_BITS-1:1]};
                  r_bit_idx  <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'(DATA_BITS - 1)) r_state <= PARITY;
               end
            end
            PARITY: begin
               if (w_bit_hit) begin
                  r_baud_cnt <= '0;
                  r_par_bit  <= w_sample;
                  r_state    <= STOP;
               end
            end
            STOP: begin
               if (w_bit_hit) begin
                  r_baud_cnt <= '0;
                  r_valid    <= 1'b1;
                  r_data     <= r_shift;
                  r_par_err  <= r_par_bit ^ (^r_shift);
                  r_frm_err  <= ~w_sample;
                  r_state    <= w_sample ? IDLE : BREAK;
               end
            end
            BREAK: begin
               if (w_rx_s) begin
                  r_baud_cnt <= '0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_baud_cnt <= '0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign data_out   = r_data;
   assign valid      = r_valid;
   assign parity_err = r_par_err;
   assign frame_err  = r_frm_err;
   assign busy       = (r_state != IDLE);

endmodule
